dmem_sized: RTL
===============

# dmem_sized

Sized, byte-lane data memory for the RISC-V datapath. It serves RV32 loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with per-lane byte enables and sign/zero extension. Requests arrive over a valid/ready handshake and responses leave as a registered result with an error flag. It sits between the ALU/register-file outputs and the writeback mux, and adds sized access and misalignment handling that the plain word memory lacks.

## Interface
- `WIDTH`, 32: data width in bits. Only 32 is legal.
- `MEM_DEPTH`, 1024: memory size in bytes. Power of two, at least 8.
- `ADDR_WIDTH`, 10: number of address bits used. Equals log2(`MEM_DEPTH`).
- `clk` in 1: clock. All state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `dmem_sel` in 1: 1 = store, 0 = load.
- `funct3` in 3: access size and sign, using RISC-V load/store encoding.
- `aluout` in `WIDTH`: byte address. Only the low `ADDR_WIDTH` bits are used.
- `rs2_out` in `WIDTH`: store data, taken from its low bytes.
- `rsp_valid` out 1: one-cycle pulse when a request completes.
- `rsp_err` out 1: qualified by `rsp_valid`. Set for a misaligned or illegal request.
- `dmem_out` out `WIDTH`: load result, qualified by `rsp_valid`.

## Operation
- Storage is 4 byte lanes, each `MEM_DEPTH`/4 entries deep.
  - Word index = addr[`ADDR_WIDTH`-1:2].
  - Lane = addr[1:0].
  - Contents are not reset.
- A request is accepted when `req_valid` && `req_ready` at a clock edge.
- Size decode from `funct3`:
  - 000 = B, 100 = BU.
  - 001 = H, 101 = HU.
  - 010 = W.
  - 011, 110, 111 = illegal. Illegal codes produce `rsp_err`=1, no write, and `dmem_out`=0.
- Stores:
  - Byte `rs2_out`[7:0] goes to lane a.
  - Half `rs2_out`[15:0] goes to lanes a and a+1, little-endian.
  - Word `rs2_out`[31:0] goes to lanes 0–3.
  - A store response has `rsp_err`=0 and `dmem_out`=0.
- Loads:
  - B / H results are sign-extended from bit 7 / bit 15.
  - BU / HU results are zero-extended.
  - W results are returned as stored.
- Misaligned means a half with addr[0]=1, or a word with addr[1:0]≠0. Handling depends on `DMEM_MISALIGN_SPLIT_EN`.
- Address wrap: addr + k is taken modulo `MEM_DEPTH`. A split access at the top word wraps to word 0.
- FSM:
  - IDLE: `req_ready`=1.
    - Aligned or illegal request: complete in one cycle, stay in IDLE.
    - Misaligned request with split enabled: access the low-part lanes of word w, capture partial read bytes, go to SPLIT.
  - SPLIT: `req_ready`=0.
    - Access the remaining lanes of word w+1 (wrapped).
    - Merge with the captured bytes, register the response, return to IDLE.
- Ordering: a load issued in the cycle after a store returns the stored data. The store commits at the edge before the load reads.

## Timing
- Reset values: `req_ready`=1 (IDLE), `rsp_valid`=0, `rsp_err`=0, `dmem_out`=0. FSM returns to IDLE.
- Aligned or illegal request accepted at edge N: `rsp_valid`=1 during cycle N+1. Throughput is one request per cycle.
- Split request accepted at edge N:
  - `req_ready`=0 during cycle N+1.
  - `rsp_valid`=1 during cycle N+2.
- `rsp_valid` is a single-cycle pulse. There is no response back-pressure.
- Requests presented while `req_ready`=0 are ignored. The requester holds them.
- `rst` asserted during SPLIT:
  - Bytes written at the first edge stay written.
  - The second part is dropped and no response is issued.

## Configuration
- `DMEM_MISALIGN_SPLIT_EN` defined: misaligned H/HU/W requests are split into two beats. They complete correctly with `rsp_err`=0 and a 2-cycle latency.
- Not defined:
  - The SPLIT state and capture registers are not built.
  - A misaligned request responds at N+1 with `rsp_err`=1 and `dmem_out`=0.
  - No memory byte is modified.

## Test plan
- Reset, then SW 0x8765_4321 @0x10. LW @0x10 gives 0x8765_4321. LB @0x13 gives 0xFFFF_FF87. LBU @0x13 gives 0x0000_0087. LH @0x12 gives 0xFFFF_8765. LHU @0x10 gives 0x0000_4321.
- SB 0xAA @0x21 over a word of 0. LW @0x20 gives 0x0000_AA00, so adjacent lanes are untouched.
- Back-to-back SW 0x1234_5678 @0x30, then LW @0x30 on the next cycle. The result is 0x1234_5678, `req_ready` stays 1, and there is one `rsp_valid` per cycle.
- Misaligned SW 0xDEAD_BEEF @0x3FE (top of a 1024-byte memory), then LW @0x3FE:
  - With the macro: `req_ready` drops for one cycle, the response arrives at N+2 as 0xDEAD_BEEF, and bytes 0x000/0x001 hold 0xAD/0xDE.
  - Without the macro: `rsp_err`=1 and memory is unchanged.
- `funct3`=011 with `dmem_sel`=1 @0x40. Response has `rsp_err`=1, and a following LW @0x40 returns the prior value.
- Misaligned SW 0x1122_3344 @0x51 with the macro, `rst` pulsed during SPLIT.
  - No `rsp_valid`; `req_ready`=1 after reset.
  - LW @0x50 shows only bytes 0x51–0x53 updated (0x44, 0x33, 0x22 at lanes 1–3).

Source files
------------

// File: rtl/dmem_sized.sv
// dmem_sized: byte-lane RV32 data memory with sized loads/stores, sign/zero extension and
// misalignment handling. Define DMEM_MISALIGN_SPLIT_EN to split misaligned H/W accesses in two beats.
//
// state | meaning
// IDLE  | accepting requests; aligned and illegal requests complete in one cycle
// SPLIT | second beat of a misaligned access, touching the next (wrapped) word

module dmem_sized #(
    parameter int WIDTH      = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             dmem_sel,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] aluout,
    input  logic [WIDTH-1:0] rs2_out,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] dmem_out
);
    localparam int WORDS = MEM_DEPTH / 4;
    localparam int WIDX  = ADDR_WIDTH - 2;

    logic [7:0] lane_mem [4][WORDS];

    logic [ADDR_WIDTH-1:0] op_addr;
    logic [2:0]            op_f3;
    logic                  op_st;
    logic [31:0]           op_data;
    logic                  beat2;
    logic [3:0][7:0]       merge_base;

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;

    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [2:0]            hold_f3;
    logic                  hold_st;
    logic [31:0]           hold_data;
    logic [3:0][7:0]       cap;

    // In SPLIT the held request drives the datapath; the live inputs are ignored
    assign beat2      = (state == SPLIT);
    assign op_addr    = beat2 ? hold_addr : aluout[ADDR_WIDTH-1:0];
    assign op_f3      = beat2 ? hold_f3 : funct3;
    assign op_st      = beat2 ? hold_st : dmem_sel;
    assign op_data    = beat2 ? hold_data : rs2_out[31:0];
    assign merge_base = beat2 ? cap : '0;
`else
    localparam bit SPLIT_EN = 1'b0;

    assign beat2      = 1'b0;
    assign op_addr    = aluout[ADDR_WIDTH-1:0];
    assign op_f3      = funct3;
    assign op_st      = dmem_sel;
    assign op_data    = rs2_out[31:0];
    assign merge_base = '0;
    assign req_ready  = 1'b1;
`endif

    logic unused_bits;
    assign unused_bits = ^aluout[WIDTH-1:ADDR_WIDTH];

    logic [1:0]      a_lo;
    logic [WIDX-1:0] widx;
    logic [2:0]      nbytes;
    logic            legal;
    logic            misal;
    logic            fire;

    assign a_lo  = op_addr[1:0];
    assign widx  = op_addr[ADDR_WIDTH-1:2] + WIDX'(beat2);
    assign legal = (op_f3[1:0] != 2'b11) && (op_f3 != 3'b110);
    assign misal = ((op_f3[1:0] == 2'b01) && a_lo[0]) ||
                   ((op_f3[1:0] == 2'b10) && (a_lo != 2'b00));
    // Gated by rst so nothing is written while reset holds the FSM in IDLE
    assign fire  = !rst && (beat2 || (req_valid && legal && (!misal || SPLIT_EN)));

    always_comb begin
        case (op_f3[1:0])
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    logic [1:0]      lane_k [4];
    logic [3:0]      lane_act;
    logic [7:0]      rbyte [4];
    logic [7:0]      wbyte [4];
    logic [3:0][7:0] load_bytes;

    // lane_k is the byte offset within the access; the first beat covers lanes >= a_lo
    always_comb begin
        load_bytes = merge_base;
        for (int l = 0; l < 4; l++) begin
            lane_k[l]   = 2'(l) - a_lo;
            lane_act[l] = ({1'b0, lane_k[l]} < nbytes) && ((2'(l) >= a_lo) != beat2);
            rbyte[l]    = lane_mem[l][widx];
            wbyte[l]    = op_data[{lane_k[l], 3'b000} +: 8];
            if (lane_act[l])
                load_bytes[lane_k[l]] = rbyte[l];
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++)
            if (fire && op_st && lane_act[l])
                lane_mem[l][widx] <= wbyte[l];
    end

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [3:0][7:0] b);
        case (f3)
            3'b000:  extend = {{24{b[0][7]}}, b[0]};
            3'b100:  extend = {24'h0, b[0]};
            3'b001:  extend = {{16{b[1][7]}}, b[1], b[0]};
            3'b101:  extend = {16'h0, b[1], b[0]};
            default: extend = b;
        endcase
    endfunction

`ifdef DMEM_MISALIGN_SPLIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            dmem_out  <= '0;
            hold_addr <= '0;
            hold_f3   <= '0;
            hold_st   <= 1'b0;
            hold_data <= '0;
            cap       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!legal) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            dmem_out  <= '0;
                        end else if (misal) begin
                            state     <= SPLIT;
                            req_ready <= 1'b0;
                            hold_addr <= op_addr;
                            hold_f3   <= op_f3;
                            hold_st   <= op_st;
                            hold_data <= op_data;
                            cap       <= load_bytes;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            dmem_out  <= op_st ? '0 : WIDTH'(extend(op_f3, load_bytes));
                        end
                    end
                end
                SPLIT: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    dmem_out  <= op_st ? '0 : WIDTH'(extend(op_f3, load_bytes));
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            dmem_out  <= '0;
        end else begin
            rsp_valid <= req_valid;
            if (req_valid) begin
                rsp_err  <= !legal || misal;
                dmem_out <= (!legal || misal || op_st) ? '0 : WIDTH'(extend(op_f3, load_bytes));
            end
        end
    end
`endif

endmodule
